// File: rtl/regfile_bypass_sb.sv
// Register file with NUM_RD combinational read ports, one write port, optional write-to-read bypass and a RAW pending scoreboard.
// Reads are combinational; writes, pending bits and pend_cnt update on the next clock edge. There is no backpressure.
module regfile_bypass_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic [ADDR_W-1:0] ra;
    logic              wr_ok;

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A new producer's set beats the old producer's writeback clear.
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (iss_en && (iss_addr == ADDR_W'(r))) begin
                    pending_nxt[r] = 1'b1;
                end else if (wr_en && (wr_addr == ADDR_W'(r))) begin
                    pending_nxt[r] = 1'b0;
                end
            end
        end
        if (ZERO_REG != 0) begin
            pending_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Reset also masks the bypass path so outputs read zero while rst is high.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (rst) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k]                  = 1'b0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k]                  = 1'b0;
            end else if ((BYPASS != 0) && wr_en && (wr_addr == ra)) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
                rd_busy[k]                  = 1'b0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs[ra];
                rd_busy[k]                  = pending[ra];
            end
        end
    end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
Parametrised successor to the core register file. It provides N combinational read ports, one synchronous write port and optional write-to-read bypass. It also holds a per-register pending-write scoreboard so the pipelined MIPS decode stage can detect RAW hazards. It sits between the decode stage (reads, issue) and the writeback stage (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only
ZERO_REG, 1, 1 = register 0 hardwired to zero and never pending

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, port k at bits [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  port k source register has an outstanding producer
wr_en  in  1  writeback write enable
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
iss_en  in  1  instruction issued with a destination register
iss_addr  in  ADDR_W  destination of the issued instruction
flush  in  1  pipeline flush: clear all pending bits
pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (rst=1, asynchronous): all registers = 0, all pending bits = 0, pend_cnt = 0. While rst is high, rd_data = 0 and rd_busy = 0 on all ports. Reset mid-operation discards any in-flight write/issue in that cycle.
- Write: on clk rise, if wr_en and not (ZERO_REG and wr_addr==0), reg[wr_addr] <= wr_data. Latency 1 cycle into the array.
- Read, combinational, per port k:
  - If ZERO_REG and rd_addr_k==0: rd_data_k = 0.
  - Else if BYPASS and wr_en and wr_addr==rd_addr_k: rd_data_k = wr_data.
  - Else: rd_data_k = reg[rd_addr_k].
  - Multiple ports may read the same address; each gets the same value.
- Scoreboard, per register r, pending[r] next-state priority:
  1. flush: pending[r] <= 0 for all r. iss_en is ignored that cycle; wr_en still writes data.
  2. iss_en and iss_addr==r: pending[r] <= 1. Set wins over a same-cycle clear to the same register, since the new producer supersedes the one writing back.
  3. wr_en and wr_addr==r: pending[r] <= 0.
  4. Otherwise hold.
  - With ZERO_REG, pending[0] is constant 0; issue/write to r0 has no effect.
- rd_busy_k = pending[rd_addr_k], except:
  - Forced 0 when ZERO_REG and rd_addr_k==0.
  - Forced 0 when BYPASS and wr_en and wr_addr==rd_addr_k, because the data is forwarded now.
  - With BYPASS=0, a same-cycle write does not clear rd_busy until the next cycle.
- pend_cnt: registered population count of the pending bits, updated on the same edge. Range 0..2**ADDR_W (r0 excluded when ZERO_REG). Never wraps; the width is sized for all-pending.
- Writing a register that is not pending is legal: data is written, pending stays 0, pend_cnt unchanged.
- Issuing to an already-pending register is legal: it stays 1 and pend_cnt is unchanged.
- No X propagation: all outputs are defined for every input once out of reset.

Test Plan:
- Reset: assert rst async mid-cycle after writing reg5=0x1234 -> immediately rd_data=0, rd_busy=0, pend_cnt=0. Release and read reg5 -> 0x00000000.
- Write/read with bypass: wr_en, wr_addr=7, wr_data=0xDEADBEEF, rd_addr0=7 same cycle -> rd_data0=0xDEADBEEF combinationally. Next cycle with wr_en=0 -> still 0xDEADBEEF from the array. With BYPASS=0, same-cycle read -> old value 0.
- Zero register: write 0xFFFFFFFF to r0 and issue r0 -> rd_data=0, rd_busy=0, pend_cnt=0.
- Scoreboard: issue r3, then r9 -> pend_cnt 1 then 2, rd_busy for r3=1. Writeback r3 -> with BYPASS=1, rd_busy=0 in the write cycle; pend_cnt=1 after the edge.
- Simultaneous issue and write to r4 while pending -> r4 data updated, pending stays 1, pend_cnt unchanged. Issue r6 with flush -> all pending 0, pend_cnt=0, r6 not pending.
- Multi-port (NUM_RD=4): all four ports read r2=0x55, r0, r31=0xAA, r2 -> 0x55, 0, 0xAA, 0x55, with independent rd_busy bits matching the pending state.
